port_request_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one downstream resource port (e.g. a memory or I/O unit) between `PORTCOUNT` requesters. It uses a rotating-priority, lowest-set-bit-after-pointer selection to pick one requester and registers its payload. It presents the payload to the resource with a valid/ready handshake, then holds the resource locked until the resource signals completion or a watchdog expires. It sits between the processor's port request vectors and the shared resource, inside processor control.

---
 rtl/port_request_arbiter_if.sv | 28 ++
 rtl/port_request_arbiter.sv | 128 ++++++++++++
 tb/tb_port_request_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/port_request_arbiter_if.sv
// Request/resource bundle shared by the port arbiter and its environment.
// The slave view belongs to the arbiter; the master view to requesters and the resource.
interface port_request_arbiter_if #(
   parameter int PORTCOUNT     = 4,
   parameter int PORTADDRWIDTH = 2,
   parameter int DATAWIDTH     = 32
);
   logic [PORTCOUNT-1:0]           ReqValid;
   logic [PORTCOUNT*DATAWIDTH-1:0] ReqData;
   logic [PORTCOUNT-1:0]           ReqACK;
   logic                           ResValid;
   logic [DATAWIDTH-1:0]           ResData;
   logic [PORTADDRWIDTH-1:0]       ResPort;
   logic                           ResReady;
   logic                           ResDone;
   logic                           ResTimeout;
   logic                           Busy;

   modport slave (
      input  ReqValid, ReqData, ResReady, ResDone,
      output ReqACK, ResValid, ResData, ResPort, ResTimeout, Busy
   );

   modport master (
      output ReqValid, ReqData, ResReady, ResDone,
      input  ReqACK, ResValid, ResData, ResPort, ResTimeout, Busy
   );
endinterface

// File: rtl/port_request_arbiter.sv
// Round-robin arbiter sharing one resource port among PORTCOUNT requesters,
// with valid/ready issue, lock until done, and a watchdog abort.
module port_request_arbiter #(
   parameter int PORTCOUNT     = 4,
   parameter int PORTADDRWIDTH = 2,
   parameter int DATAWIDTH     = 32,
   parameter int TIMEOUTWIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  sync_rst,
   input  logic                  clk_en,
   port_request_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                   state, nextState;
   logic [PORTADDRWIDTH-1:0] PriorityIndex;
   logic [TIMEOUTWIDTH-1:0]  watchdog;
   logic [TIMEOUTWIDTH-1:0]  watchdogNext;
   logic [DATAWIDTH-1:0]     resDataReg;
   logic [PORTADDRWIDTH-1:0] resPortReg;
   logic                     resTimeoutReg;

   logic [2*PORTCOUNT-1:0]   doubled;
   logic [PORTCOUNT-1:0]     rotated;
   logic [PORTADDRWIDTH-1:0] rotIdx;
   logic [PORTADDRWIDTH-1:0] winner;
   logic                     found;
   logic [PORTCOUNT-1:0]     grant;
   logic                     loadGrant;
   logic                     clearWatchdog;
   logic                     countWatchdog;
   logic                     setTimeout;

   // Rotating the doubled vector gives a wrap-around right rotate without variable-width shifts.
   always_comb begin
      doubled = {bus.ReqValid, bus.ReqValid} >> PriorityIndex;
      rotated = doubled[PORTCOUNT-1:0];
      rotIdx  = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < PORTCOUNT; i++) begin
         if (!found && rotated[i]) begin
            rotIdx = PORTADDRWIDTH'(i);
            found  = 1'b1;
         end
      end
      winner = rotIdx + PriorityIndex;
   end

   assign watchdogNext = watchdog + TIMEOUTWIDTH'(1);

   always_comb begin
      nextState     = state;
      grant         = '0;
      loadGrant     = 1'b0;
      clearWatchdog = 1'b0;
      countWatchdog = 1'b0;
      setTimeout    = 1'b0;
      case (state)
         IDLE: begin
            if (clk_en && (|bus.ReqValid)) begin
               grant[winner] = 1'b1;
               loadGrant     = 1'b1;
               nextState     = ISSUE;
            end
         end
         ISSUE: begin
            if (clk_en && bus.ResReady) begin
               if (bus.ResDone) begin
                  nextState = IDLE;
               end else begin
                  nextState     = WAIT;
                  clearWatchdog = 1'b1;
               end
            end
         end
         WAIT: begin
            if (clk_en) begin
               countWatchdog = 1'b1;
               if (bus.ResDone) begin
                  nextState = IDLE;
               end else if (watchdogNext == '1) begin
                  setTimeout = 1'b1;
                  nextState  = IDLE;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state         <= IDLE;
         PriorityIndex <= '0;
         watchdog      <= '0;
         resDataReg    <= '0;
         resPortReg    <= '0;
         resTimeoutReg <= 1'b0;
      end else if (clk_en) begin
         state         <= nextState;
         resTimeoutReg <= setTimeout;
         if (loadGrant) begin
            resDataReg    <= bus.ReqData[winner*DATAWIDTH +: DATAWIDTH];
            resPortReg    <= winner;
            PriorityIndex <= winner + PORTADDRWIDTH'(1);
         end
         if (clearWatchdog) begin
            watchdog <= '0;
         end else if (countWatchdog) begin
            watchdog <= watchdogNext;
         end
      end
   end

   assign bus.ReqACK     = sync_rst ? '0 : grant;
   assign bus.ResValid   = (state == ISSUE);
   assign bus.ResData    = resDataReg;
   assign bus.ResPort    = resPortReg;
   assign bus.ResTimeout = resTimeoutReg;
   assign bus.Busy       = (state != IDLE);

endmodule

// File: tb/tb_port_request_arbiter.sv
// Directed-vector bench for port_request_arbiter (4 ports, 32-bit data, 3-bit watchdog).
module tb_port_request_arbiter;

   logic clk;
   logic sync_rst;
   logic clk_en;
   int   assertCount;
   int   failCount;

   port_request_arbiter_if #(.PORTCOUNT(4), .PORTADDRWIDTH(2), .DATAWIDTH(32)) bus ();

   port_request_arbiter #(
      .PORTCOUNT(4),
      .PORTADDRWIDTH(2),
      .DATAWIDTH(32),
      .TIMEOUTWIDTH(3)
   ) dut (
      .clk(clk),
      .sync_rst(sync_rst),
      .clk_en(clk_en),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1, "time limit");
   end

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setData(input int port, input logic [31:0] value);
      bus.ReqData[port*32 +: 32] = value;
   endtask

   initial begin
      logic [3:0] expOrder [5];
      assertCount = 0;
      failCount   = 0;
      expOrder    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

      sync_rst     = 1'b1;
      clk_en       = 1'b1;
      bus.ReqValid = 4'b1111;
      bus.ReqData  = '0;
      bus.ResReady = 1'b0;
      bus.ResDone  = 1'b0;
      for (int i = 0; i < 4; i++) setData(i, 32'h1000_0000 + 32'(i));
      tick();
      tick();

      checkVal("rst_ReqACK", 32'(bus.ReqACK), 32'h0);
      checkVal("rst_ResValid", 32'(bus.ResValid), 32'h0);
      checkVal("rst_Busy", 32'(bus.Busy), 32'h0);
      checkVal("rst_ResData", bus.ResData, 32'h0);
      checkVal("rst_ResPort", 32'(bus.ResPort), 32'h0);
      checkVal("rst_ResTimeout", 32'(bus.ResTimeout), 32'h0);
      checkVal("rst_PriorityIndex", 32'(dut.PriorityIndex), 32'h0);

      // Round-robin with all ports requesting and immediate completion.
      sync_rst     = 1'b0;
      bus.ResReady = 1'b1;
      bus.ResDone  = 1'b1;
      #1;
      for (int t = 0; t < 5; t++) begin
         checkVal("rr_ReqACK", 32'(bus.ReqACK), 32'h1 << expOrder[t]);
         tick();
         checkVal("rr_ResValid", 32'(bus.ResValid), 32'h1);
         checkVal("rr_ResPort", 32'(bus.ResPort), 32'(expOrder[t]));
         checkVal("rr_ResData", bus.ResData, 32'h1000_0000 + 32'(expOrder[t]));
         checkVal("rr_PriorityIndex", 32'(dut.PriorityIndex), 32'((expOrder[t] + 1) % 4));
         checkVal("rr_ReqACK_issue", 32'(bus.ReqACK), 32'h0);
         tick();
         checkVal("rr_Busy_idle", 32'(bus.Busy), 32'h0);
      end

      // Move the pointer to 3 by granting port 2, then check selection from 3.
      bus.ReqValid = 4'b0100;
      #1;
      checkVal("p2_ReqACK", 32'(bus.ReqACK), 32'h4);
      tick();
      checkVal("p2_PriorityIndex", 32'(dut.PriorityIndex), 32'h3);
      tick();
      bus.ReqValid = 4'b0110;
      #1;
      checkVal("pi3_ReqACK", 32'(bus.ReqACK), 32'h2);
      tick();
      checkVal("pi3_ResPort", 32'(bus.ResPort), 32'h1);
      checkVal("pi3_PriorityIndex", 32'(dut.PriorityIndex), 32'h2);
      tick();

      // Grant port 2 and stall the resource for 5 cycles.
      bus.ReqValid = 4'b0100;
      bus.ResReady = 1'b0;
      bus.ResDone  = 1'b0;
      setData(2, 32'hDEAD_BEEF);
      #1;
      checkVal("hold_grant", 32'(bus.ReqACK), 32'h4);
      tick();
      setData(2, 32'h0);
      bus.ReqValid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         checkVal("hold_ResValid", 32'(bus.ResValid), 32'h1);
         checkVal("hold_ResData", bus.ResData, 32'hDEAD_BEEF);
         checkVal("hold_ResPort", 32'(bus.ResPort), 32'h2);
         checkVal("hold_ReqACK", 32'(bus.ReqACK), 32'h0);
         tick();
      end

      // Accept without completion, then let the watchdog expire.
      bus.ReqValid = 4'b0000;
      bus.ResReady = 1'b1;
      tick();
      bus.ResReady = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         checkVal("to_Busy", 32'(bus.Busy), 32'h1);
         checkVal("to_ResValid", 32'(bus.ResValid), 32'h0);
         checkVal("to_early", 32'(bus.ResTimeout), 32'h0);
         tick();
      end
      checkVal("to_pulse", 32'(bus.ResTimeout), 32'h1);
      checkVal("to_idle", 32'(bus.Busy), 32'h0);
      tick();
      checkVal("to_single", 32'(bus.ResTimeout), 32'h0);

      // Same, but ResDone lands on the expiry cycle: no pulse.
      bus.ReqValid = 4'b0001;
      bus.ResReady = 1'b1;
      #1;
      checkVal("dw_grant", 32'(bus.ReqACK), 32'h1);
      tick();
      bus.ReqValid = 4'b0000;
      tick();
      bus.ResReady = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         checkVal("dw_Busy", 32'(bus.Busy), 32'h1);
         tick();
      end
      bus.ResDone = 1'b1;
      #1;
      checkVal("dw_Busy7", 32'(bus.Busy), 32'h1);
      tick();
      bus.ResDone = 1'b0;
      checkVal("dw_nopulse", 32'(bus.ResTimeout), 32'h0);
      checkVal("dw_idle", 32'(bus.Busy), 32'h0);
      tick();
      checkVal("dw_nopulse2", 32'(bus.ResTimeout), 32'h0);

      // Freeze in WAIT with clk_en low; timeout then needs 4 more enabled cycles.
      bus.ReqValid = 4'b0010;
      bus.ResReady = 1'b1;
      #1;
      checkVal("ce_grant", 32'(bus.ReqACK), 32'h2);
      tick();
      bus.ReqValid = 4'b0000;
      tick();
      bus.ResReady = 1'b0;
      for (int k = 1; k <= 3; k++) tick();
      clk_en       = 1'b0;
      bus.ReqValid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkVal("ce_Busy", 32'(bus.Busy), 32'h1);
         checkVal("ce_ReqACK", 32'(bus.ReqACK), 32'h0);
         checkVal("ce_ResValid", 32'(bus.ResValid), 32'h0);
         checkVal("ce_ResTimeout", 32'(bus.ResTimeout), 32'h0);
         checkVal("ce_ResPort", 32'(bus.ResPort), 32'h1);
         tick();
      end
      clk_en       = 1'b1;
      bus.ReqValid = 4'b0000;
      for (int k = 4; k <= 7; k++) begin
         #1;
         checkVal("ce_resume_Busy", 32'(bus.Busy), 32'h1);
         tick();
      end
      checkVal("ce_pulse", 32'(bus.ResTimeout), 32'h1);
      checkVal("ce_idle", 32'(bus.Busy), 32'h0);
      tick();

      // Reset during ISSUE aborts silently.
      bus.ReqValid = 4'b0001;
      #1;
      checkVal("rs_grant", 32'(bus.ReqACK), 32'h1);
      tick();
      checkVal("rs_issue", 32'(bus.ResValid), 32'h1);
      sync_rst = 1'b1;
      #1;
      checkVal("rs_ReqACK_forced", 32'(bus.ReqACK), 32'h0);
      tick();
      checkVal("rs_ResValid", 32'(bus.ResValid), 32'h0);
      checkVal("rs_Busy", 32'(bus.Busy), 32'h0);
      checkVal("rs_PriorityIndex", 32'(dut.PriorityIndex), 32'h0);
      checkVal("rs_ResTimeout", 32'(bus.ResTimeout), 32'h0);
      sync_rst     = 1'b0;
      bus.ReqValid = 4'b0000;
      tick();
      checkVal("rs_after", 32'(bus.ResTimeout), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
